imm_gen_pipe: RTL and testbench

//  Multi-lane, registered immediate generator for the superscalar decode stage.

---
 rtl/imm_gen_pipe.sv | 180 ++++++++++++++++++
 tb/tb_imm_gen_pipe.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: multi-lane registered immediate generator for the decode stage.
// Each lane decodes opcode[6:0] into a sign-extended XLEN immediate, a 3-bit
// format code and an illegal flag. Results are registered behind a valid/ready
// handshake with an output register (OUT) and a skid register (SKID).
// Ports:
//   clk, reset (async, active-high), flush (sync, drops all held beats)
//   in_valid/in_ready, in_lane_valid[LANES], in_instr[LANES*32]
//   out_valid/out_ready, out_lane_valid[LANES], out_imm[LANES*XLEN],
//   out_fmt[LANES*3], out_illegal[LANES]

// imm_gen_lane: combinational decode of one instruction slot.
// Ports: lane_valid, instr[31:0] in; imm[XLEN], fmt[3], illegal out.
module imm_gen_lane #(
    parameter int XLEN = 32
) (
    input  logic            lane_valid,
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt,
    output logic            illegal
);
    localparam logic [2:0] FMT_R = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2, FMT_B = 3'd3,
                           FMT_U = 3'd4, FMT_J = 3'd5, FMT_SH = 3'd6, FMT_ILL = 3'd7;
    localparam bit RV64 = (XLEN == 64);

    logic [6:0]  opcode;
    logic        is_shift;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [XLEN-1:0] shamt;

    assign opcode   = instr[6:0];
    assign is_shift = (instr[14:12] == 3'b001) || (instr[14:12] == 3'b101);

    // All formats are built as 32-bit signed values, then sign-extended to XLEN.
    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // Only the full-width OP-IMM shifts get a 6-bit shamt on RV64; the *W shifts stay 5-bit.
    assign shamt = (RV64 && opcode == 7'b0010011) ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);

    always_comb begin
        imm     = '0;
        fmt     = FMT_R;
        illegal = 1'b0;
        if (lane_valid) begin
            case (opcode)
                7'b0000011, 7'b1100111: begin
                    imm = XLEN'(signed'(imm_i));
                    fmt = FMT_I;
                end
                7'b0010011: begin
                    imm = is_shift ? shamt : XLEN'(signed'(imm_i));
                    fmt = is_shift ? FMT_SH : FMT_I;
                end
                7'b0011011: begin
                    if (RV64) begin
                        imm = is_shift ? shamt : XLEN'(signed'(imm_i));
                        fmt = is_shift ? FMT_SH : FMT_I;
                    end else begin
                        fmt     = FMT_ILL;
                        illegal = 1'b1;
                    end
                end
                7'b0100011: begin
                    imm = XLEN'(signed'(imm_s));
                    fmt = FMT_S;
                end
                7'b1100011: begin
                    imm = XLEN'(signed'(imm_b));
                    fmt = FMT_B;
                end
                7'b0110111, 7'b0010111: begin
                    imm = XLEN'(signed'(imm_u));
                    fmt = FMT_U;
                end
                7'b1101111: begin
                    imm = XLEN'(signed'(imm_j));
                    fmt = FMT_J;
                end
                7'b0110011, 7'b0001111, 7'b1110011: fmt = FMT_R;
                7'b0111011: begin
                    if (!RV64) begin
                        fmt     = FMT_ILL;
                        illegal = 1'b1;
                    end
                end
                default: begin
                    fmt     = FMT_ILL;
                    illegal = 1'b1;
                end
            endcase
        end
    end
endmodule

module imm_gen_pipe #(
    parameter int LANES = 2,
    parameter int XLEN  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES-1:0]      in_lane_valid,
    input  logic [LANES*32-1:0]   in_instr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES-1:0]      out_lane_valid,
    output logic [LANES*XLEN-1:0] out_imm,
    output logic [LANES*3-1:0]    out_fmt,
    output logic [LANES-1:0]      out_illegal
);
    typedef struct packed {
        logic [LANES-1:0]           lv;
        logic [LANES-1:0][XLEN-1:0] imm;
        logic [LANES-1:0][2:0]      fmt;
        logic [LANES-1:0]           ill;
    } beat_t;

    logic [LANES-1:0][XLEN-1:0] dec_imm;
    logic [LANES-1:0][2:0]      dec_fmt;
    logic [LANES-1:0]           dec_ill;
    beat_t dec, out_q, skid_q;
    logic  out_vld, skid_vld;
    logic  accept, out_free;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        imm_gen_lane #(.XLEN(XLEN)) u_lane (
            .lane_valid (in_lane_valid[g]),
            .instr      (in_instr[32*g +: 32]),
            .imm        (dec_imm[g]),
            .fmt        (dec_fmt[g]),
            .illegal    (dec_ill[g])
        );
    end

    assign dec = '{lv: in_lane_valid, imm: dec_imm, fmt: dec_fmt, ill: dec_ill};

    // in_ready depends only on registered state, so out_ready never reaches it combinationally.
    assign in_ready = !skid_vld;
    assign accept   = in_valid && in_ready;
    assign out_free = !out_vld || out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_vld  <= 1'b0;
            skid_vld <= 1'b0;
            out_q    <= '0;
            skid_q   <= '0;
        end else if (flush) begin
            out_vld  <= 1'b0;
            skid_vld <= 1'b0;
        end else if (out_free) begin
            if (skid_vld) begin
                out_q    <= skid_q;
                out_vld  <= 1'b1;
                skid_vld <= accept;
                if (accept) skid_q <= dec;
            end else if (accept) begin
                out_q   <= dec;
                out_vld <= 1'b1;
            end else begin
                out_vld <= 1'b0;
            end
        end else if (accept) begin
            skid_q   <= dec;
            skid_vld <= 1'b1;
        end
    end

    assign out_valid      = out_vld;
    assign out_lane_valid = out_q.lv;
    assign out_imm        = out_q.imm;
    assign out_fmt        = out_q.fmt;
    assign out_illegal    = out_q.ill;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: a LANES=2/XLEN=32 instance for decode and
// handshake scenarios, and a LANES=1/XLEN=64 instance for RV64 decode.
module tb_imm_gen_pipe;
    logic        clk = 1'b0, reset = 1'b1, flush = 1'b0;
    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
    logic [1:0]  in_lane_valid = '0, out_lane_valid, out_illegal;
    logic [63:0] in_instr = '0, out_imm;
    logic [5:0]  out_fmt;

    logic        v_in_valid = 1'b0, v_in_ready, v_out_valid;
    logic [0:0]  v_in_lane_valid = '0, v_out_lane_valid, v_out_illegal;
    logic [31:0] v_in_instr = '0;
    logic [63:0] v_out_imm;
    logic [2:0]  v_out_fmt;

    int nvec = 0, nerr = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.LANES(2), .XLEN(32)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_lane_valid(in_lane_valid),
        .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready),
        .out_lane_valid(out_lane_valid), .out_imm(out_imm), .out_fmt(out_fmt),
        .out_illegal(out_illegal)
    );

    imm_gen_pipe #(.LANES(1), .XLEN(64)) dut64 (
        .clk(clk), .reset(reset), .flush(1'b0),
        .in_valid(v_in_valid), .in_ready(v_in_ready), .in_lane_valid(v_in_lane_valid),
        .in_instr(v_in_instr), .out_valid(v_out_valid), .out_ready(1'b1),
        .out_lane_valid(v_out_lane_valid), .out_imm(v_out_imm), .out_fmt(v_out_fmt),
        .out_illegal(v_out_illegal)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // addi x0,x0,k on lane 0 only: imm0=k, fmt0=1
    function automatic logic [31:0] addi(input int k);
        return {12'(k), 20'h00013};
    endfunction

    task automatic test_reset;
        #1;
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        nvec++; if ({out_lane_valid, out_illegal, out_fmt, out_imm} !== '0)
            begin nerr++; $display("FAIL reset_data got lv=%b ill=%b fmt=%h imm=%h exp 0", out_lane_valid, out_illegal, out_fmt, out_imm); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_formats;
        logic [31:0] i0 [6] = '{32'hFFF00093, 32'hFE000CE3, 32'h123452B7, 32'h41F0D093, 32'h0010809B, 32'h80002083};
        logic [31:0] i1 [6] = '{32'hFE20AE23, 32'h001000EF, 32'h0000007F, 32'h002081B3, 32'h0000007F, 32'h7FF0006F};
        logic [1:0]  lv [6] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b01, 2'b11};
        logic [63:0] ei [6] = '{64'hFFFFFFFC_FFFFFFFF, 64'h00000800_FFFFFFF8, 64'h00000000_12345000,
                                64'h00000000_0000001F, 64'h00000000_00000000, 64'h00000FFE_FFFFF800};
        logic [5:0]  ef [6] = '{{3'd2, 3'd1}, {3'd5, 3'd3}, {3'd7, 3'd4}, {3'd0, 3'd6}, {3'd0, 3'd7}, {3'd5, 3'd1}};
        logic [1:0]  el [6] = '{2'b00, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
        out_ready = 1'b1;
        for (int v = 0; v < 6; v++) begin
            in_valid = 1'b1; in_instr = {i1[v], i0[v]}; in_lane_valid = lv[v];
            step;
            nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL fmt%0d_valid got %b exp 1", v, out_valid); end
            nvec++; if (out_imm !== ei[v]) begin nerr++; $display("FAIL fmt%0d_imm got %h exp %h", v, out_imm, ei[v]); end
            nvec++; if (out_fmt !== ef[v]) begin nerr++; $display("FAIL fmt%0d_fmt got %h exp %h", v, out_fmt, ef[v]); end
            nvec++; if (out_illegal !== el[v]) begin nerr++; $display("FAIL fmt%0d_illegal got %b exp %b", v, out_illegal, el[v]); end
            nvec++; if (out_lane_valid !== lv[v]) begin nerr++; $display("FAIL fmt%0d_lane_valid got %b exp %b", v, out_lane_valid, lv[v]); end
        end
        in_valid = 1'b0;
        step;
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL drain_valid got %b exp 0", out_valid); end
    endtask

    task automatic test_back_to_back;
        int idx = 0, got = 0, gaps = 0;
        bit acc, fire;
        out_ready = 1'b0;
        for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
            if (cyc == 3) begin
                nvec++; if (out_valid !== 1'b1 || out_imm[31:0] !== 32'd1)
                    begin nerr++; $display("FAIL bp_hold got v=%b imm=%h exp v=1 imm=1", out_valid, out_imm[31:0]); end
                nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL bp_in_ready got %b exp 0", in_ready); end
                out_ready = 1'b1;
            end
            in_valid = (idx < 4); in_instr = {32'h0, addi(idx + 1)}; in_lane_valid = 2'b01;
            fire = out_valid && out_ready;
            acc  = in_valid && in_ready;
            if (fire) begin
                nvec++; if (out_imm[31:0] !== 32'(got + 1))
                    begin nerr++; $display("FAIL bp_order got %h exp %h", out_imm[31:0], got + 1); end
                got++;
            end else if (out_ready) gaps++;
            step;
            if (acc) idx++;
        end
        in_valid = 1'b0;
        nvec++; if (got !== 4) begin nerr++; $display("FAIL bp_count got %0d exp 4", got); end
        nvec++; if (gaps !== 0) begin nerr++; $display("FAIL bp_gaps got %0d exp 0", gaps); end
        step;
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL bp_dup got %b exp 0", out_valid); end
    endtask

    task automatic test_flush;
        out_ready = 1'b0; in_lane_valid = 2'b01; in_valid = 1'b1;
        in_instr = {32'h0, addi(5)}; step;
        in_instr = {32'h0, addi(6)}; step;
        nvec++; if (out_valid !== 1'b1 || in_ready !== 1'b0)
            begin nerr++; $display("FAIL flush_full got v=%b rdy=%b exp 1 0", out_valid, in_ready); end
        in_instr = {32'h0, addi(7)}; flush = 1'b1; step;
        flush = 1'b0; in_valid = 1'b0;
        nvec++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            begin nerr++; $display("FAIL flush_clear got v=%b rdy=%b exp 0 1", out_valid, in_ready); end
        out_ready = 1'b1; step; step;
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL flush_ghost got %b exp 0", out_valid); end
        // A beat accepted in the flush cycle itself is dropped too.
        in_valid = 1'b1; in_instr = {32'h0, addi(8)}; flush = 1'b1; step;
        flush = 1'b0;
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL flush_in_drop got %b exp 0", out_valid); end
        in_instr = {32'h0, addi(9)}; step;
        in_valid = 1'b0;
        nvec++; if (out_valid !== 1'b1 || out_imm[31:0] !== 32'd9)
            begin nerr++; $display("FAIL flush_resume got v=%b imm=%h exp 1 9", out_valid, out_imm[31:0]); end
        step;
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b0; in_lane_valid = 2'b11; in_valid = 1'b1;
        in_instr = {32'h0000007F, addi(10)}; step;
        in_instr = {32'h0000007F, addi(11)}; step;
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        nvec++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            begin nerr++; $display("FAIL rst_mid_hs got v=%b rdy=%b exp 0 1", out_valid, in_ready); end
        nvec++; if ({out_lane_valid, out_illegal, out_fmt, out_imm} !== '0)
            begin nerr++; $display("FAIL rst_mid_data got imm=%h fmt=%h ill=%b exp 0", out_imm, out_fmt, out_illegal); end
        @(negedge clk);
        reset = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1; in_lane_valid = 2'b01; in_instr = {32'h0, addi(12)};
        step;
        in_valid = 1'b0;
        nvec++; if (out_valid !== 1'b1 || out_imm !== 64'd12)
            begin nerr++; $display("FAIL rst_first_beat got v=%b imm=%h exp 1 c", out_valid, out_imm); end
        step;
    endtask

    task automatic test_xlen64;
        logic [31:0] iv [5] = '{32'h03F01093, 32'h800002B7, 32'h0010809B, 32'h0210109B, 32'h0000003B};
        logic [63:0] ei [5] = '{64'd63, 64'hFFFFFFFF_80000000, 64'd1, 64'd1, 64'd0};
        logic [2:0]  ef [5] = '{3'd6, 3'd4, 3'd1, 3'd6, 3'd0};
        for (int v = 0; v < 5; v++) begin
            v_in_valid = 1'b1; v_in_lane_valid = 1'b1; v_in_instr = iv[v];
            step;
            nvec++; if (v_out_valid !== 1'b1 || v_out_imm !== ei[v])
                begin nerr++; $display("FAIL x64_%0d_imm got v=%b imm=%h exp %h", v, v_out_valid, v_out_imm, ei[v]); end
            nvec++; if (v_out_fmt !== ef[v] || v_out_illegal !== 1'b0)
                begin nerr++; $display("FAIL x64_%0d_fmt got %0d ill=%b exp %0d", v, v_out_fmt, v_out_illegal, ef[v]); end
        end
        v_in_valid = 1'b0;
        step;
    endtask

    initial begin
        test_reset;
        test_formats;
        test_back_to_back;
        test_flush;
        test_reset_mid;
        test_xlen64;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
